id_scan_fsm: RTL and testbench

//  Streaming identifier recogniser, parametrised successor of the single-bit id checker.

---
 rtl/id_scan_fsm_if.sv | 17 +
 rtl/id_scan_fsm.sv | 83 ++++++++
 tb/tb_id_scan_fsm.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_scan_fsm_if.sv
// id_scan_fsm_if: character stream in, identifier status out
interface id_scan_fsm_if #(
    parameter int CHAR_W  = 8,
    parameter int MAX_DIG = 15,
    parameter int CNT_W   = 8
);
    localparam int DW = $clog2(MAX_DIG + 1);
    logic              clr;
    logic              in_valid;
    logic [CHAR_W-1:0] char;
    logic              out;
    logic [DW-1:0]     dig_len;
    logic              id_done;
    logic [CNT_W-1:0]  id_count;
    modport master (output clr, in_valid, char, input out, dig_len, id_done, id_count);
    modport slave  (input clr, in_valid, char, output out, dig_len, id_done, id_count);
endinterface

// File: rtl/id_scan_fsm.sv
// id_scan_fsm: flags a stream ending in <letter><digit>{1..MAX_DIG} and counts completed identifiers
module id_scan_fsm #(
    parameter int CHAR_W   = 8,
    parameter int MAX_DIG  = 15,
    parameter int CNT_W    = 8,
    parameter int ALLOW_US = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    id_scan_fsm_if.slave bus
);
    localparam int DW = $clog2(MAX_DIG + 1);
    localparam logic [CHAR_W-1:0] C_0  = CHAR_W'(8'h30);
    localparam logic [CHAR_W-1:0] C_9  = CHAR_W'(8'h39);
    localparam logic [CHAR_W-1:0] C_LA = CHAR_W'(8'h61);
    localparam logic [CHAR_W-1:0] C_LZ = CHAR_W'(8'h7A);
    localparam logic [CHAR_W-1:0] C_UA = CHAR_W'(8'h41);
    localparam logic [CHAR_W-1:0] C_UZ = CHAR_W'(8'h5A);
    localparam logic [CHAR_W-1:0] C_US = CHAR_W'(8'h5F);

    typedef enum logic [1:0] {IDLE, ALPHA, MATCH} state_t;

    state_t           state, state_nx;
    logic [DW-1:0]    dig_len, dig_nx;
    logic [CNT_W-1:0] id_count, cnt_nx;
    logic             id_done, done_nx;
    logic             is_dig, is_let;

    // classify the character, then pick next state, run length and completion pulse
    always_comb begin
        is_dig   = bus.char >= C_0 && bus.char <= C_9;
        is_let   = (bus.char >= C_LA && bus.char <= C_LZ) || (bus.char >= C_UA && bus.char <= C_UZ) ||
                   (ALLOW_US != 0 && bus.char == C_US);
        state_nx = state;
        dig_nx   = dig_len;
        cnt_nx   = id_count;
        done_nx  = 1'b0;
        if (bus.in_valid) begin
            if (state == MATCH && !is_dig) begin
                done_nx = 1'b1;
                cnt_nx  = &id_count ? id_count : id_count + CNT_W'(1);
            end
            if (is_let) begin
                state_nx = ALPHA;
                dig_nx   = '0;
            end else if (!is_dig) begin
                state_nx = IDLE;
                dig_nx   = '0;
            end else if (state == ALPHA) begin
                state_nx = MATCH;
                dig_nx   = DW'(1);
            end else if (state == MATCH) begin
                state_nx = dig_len == DW'(MAX_DIG) ? IDLE : MATCH;
                dig_nx   = dig_len == DW'(MAX_DIG) ? '0 : dig_len + DW'(1);
            end
        end
    end

    // state and status registers; clr wins over a valid character on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dig_len  <= '0;
            id_count <= '0;
            id_done  <= 1'b0;
        end else if (bus.clr) begin
            state    <= IDLE;
            dig_len  <= '0;
            id_count <= '0;
            id_done  <= 1'b0;
        end else begin
            state    <= state_nx;
            dig_len  <= dig_nx;
            id_count <= cnt_nx;
            id_done  <= done_nx;
        end
    end

    assign bus.out      = state == MATCH;
    assign bus.dig_len  = dig_len;
    assign bus.id_count = id_count;
    assign bus.id_done  = id_done;
endmodule

// File: tb/tb_id_scan_fsm.sv
// tb_id_scan_fsm: table vectors and reference-model scoreboard for two parameterisations
module tb_id_scan_fsm;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_scan_fsm_if #(.CHAR_W(8), .MAX_DIG(15), .CNT_W(8)) ifa ();
    id_scan_fsm_if #(.CHAR_W(8), .MAX_DIG(3),  .CNT_W(2)) ifb ();

    id_scan_fsm #(.CHAR_W(8), .MAX_DIG(15), .CNT_W(8), .ALLOW_US(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    id_scan_fsm #(.CHAR_W(8), .MAX_DIG(3),  .CNT_W(2), .ALLOW_US(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct { int o; int d; int dn; int cnt; } exp_t;
    typedef struct { logic v; logic c; logic [7:0] ch; int o; int d; int dn; int cnt; } vec_t;

    int checks = 0;
    int errors = 0;
    int step = 0;
    exp_t qa[$];
    exp_t qb[$];
    vec_t tab[$];

    int st[2];
    int dl[2];
    int cn[2];
    const int MAXD[2] = '{15, 3};
    const int CMAX[2] = '{255, 3};
    const int US[2]   = '{0, 1};

    function automatic vec_t mk(logic v, logic c, logic [7:0] ch, int o, int d, int dn, int cnt);
        vec_t r;
        r.v = v; r.c = c; r.ch = ch; r.o = o; r.d = d; r.dn = dn; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d actual=%0d required=%0d", nm, step, act, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; dl[i] = 0; cn[i] = 0;
        end
    endtask

    // reference model: 0 idle, 1 letter seen, 2 letter followed by digits
    task automatic mstep(input int i, input logic v, input logic c, input logic [7:0] ch, output exp_t e);
        bit isd, isl;
        e.dn = 0;
        isd = ch >= 8'h30 && ch <= 8'h39;
        isl = (ch >= 8'h61 && ch <= 8'h7a) || (ch >= 8'h41 && ch <= 8'h5a) || (US[i] == 1 && ch == 8'h5f);
        if (c) begin
            st[i] = 0; dl[i] = 0; cn[i] = 0;
        end else if (v) begin
            if (st[i] == 2 && !isd) begin
                e.dn = 1;
                if (cn[i] < CMAX[i]) cn[i]++;
            end
            if (isl) begin
                st[i] = 1; dl[i] = 0;
            end else if (!isd) begin
                st[i] = 0; dl[i] = 0;
            end else if (st[i] == 1) begin
                st[i] = 2; dl[i] = 1;
            end else if (st[i] == 2) begin
                if (dl[i] < MAXD[i]) dl[i]++;
                else begin st[i] = 0; dl[i] = 0; end
            end
        end
        e.o = st[i] == 2 ? 1 : 0;
        e.d = dl[i];
        e.cnt = cn[i];
    endtask

    task automatic cyc(input logic v, input logic c, input logic [7:0] ch, input bit use_tab, input exp_t te);
        exp_t ea, eb, pa, pb;
        ifa.in_valid = v; ifa.clr = c; ifa.char = ch;
        ifb.in_valid = v; ifb.clr = c; ifb.char = ch;
        mstep(0, v, c, ch, ea);
        mstep(1, v, c, ch, eb);
        qa.push_back(use_tab ? te : ea);
        qb.push_back(eb);
        @(posedge clk);
        #1;
        step++;
        pa = qa.pop_front();
        pb = qb.pop_front();
        chk("a_out", int'(ifa.out), pa.o);
        chk("a_dig_len", int'(ifa.dig_len), pa.d);
        chk("a_id_done", int'(ifa.id_done), pa.dn);
        chk("a_id_count", int'(ifa.id_count), pa.cnt);
        chk("b_out", int'(ifb.out), pb.o);
        chk("b_dig_len", int'(ifb.dig_len), pb.d);
        chk("b_id_done", int'(ifb.id_done), pb.dn);
        chk("b_id_count", int'(ifb.id_count), pb.cnt);
    endtask

    task automatic mc(input logic v, input logic c, input logic [7:0] ch);
        exp_t z;
        z = '{0, 0, 0, 0};
        cyc(v, c, ch, 1'b0, z);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a_out"}, int'(ifa.out), 0);
        chk({nm, "_a_dig_len"}, int'(ifa.dig_len), 0);
        chk({nm, "_a_id_done"}, int'(ifa.id_done), 0);
        chk({nm, "_a_id_count"}, int'(ifa.id_count), 0);
        chk({nm, "_b_out"}, int'(ifb.out), 0);
        chk({nm, "_b_dig_len"}, int'(ifb.dig_len), 0);
        chk({nm, "_b_id_done"}, int'(ifb.id_done), 0);
        chk({nm, "_b_id_count"}, int'(ifb.id_count), 0);
    endtask

    initial begin
        exp_t te;
        logic [7:0] ch;
        int r;
        ifa.in_valid = 0; ifa.clr = 0; ifa.char = 0;
        ifb.in_valid = 0; ifb.clr = 0; ifb.char = 0;
        mreset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        #10 rst_n = 1'b1;

        // expectations for the default instance (MAX_DIG=15, CNT_W=8, no underscore)
        tab.push_back(mk(1, 0, "a", 0, 0, 0, 0));
        tab.push_back(mk(1, 0, "b", 0, 0, 0, 0));
        tab.push_back(mk(1, 0, "1", 1, 1, 0, 0));
        tab.push_back(mk(1, 0, "2", 1, 2, 0, 0));
        tab.push_back(mk(1, 0, " ", 0, 0, 1, 1));
        tab.push_back(mk(1, 0, "1", 0, 0, 0, 1));
        tab.push_back(mk(1, 0, "2", 0, 0, 0, 1));
        tab.push_back(mk(1, 0, "a", 0, 0, 0, 1));
        tab.push_back(mk(1, 0, "3", 1, 1, 0, 1));
        tab.push_back(mk(1, 0, " ", 0, 0, 1, 2));
        tab.push_back(mk(1, 0, "a", 0, 0, 0, 2));
        tab.push_back(mk(0, 0, "9", 0, 0, 0, 2));
        tab.push_back(mk(1, 0, "1", 1, 1, 0, 2));
        tab.push_back(mk(0, 0, " ", 1, 1, 0, 2));
        tab.push_back(mk(1, 0, "b", 0, 0, 1, 3));
        tab.push_back(mk(0, 0, "5", 0, 0, 0, 3));
        tab.push_back(mk(1, 0, "2", 1, 1, 0, 3));
        tab.push_back(mk(0, 0, "z", 1, 1, 0, 3));
        tab.push_back(mk(1, 0, ";", 0, 0, 1, 4));
        tab.push_back(mk(0, 0, ";", 0, 0, 0, 4));
        tab.push_back(mk(1, 0, "_", 0, 0, 0, 4));
        tab.push_back(mk(1, 0, "9", 0, 0, 0, 4));
        tab.push_back(mk(1, 0, "z", 0, 0, 0, 4));
        tab.push_back(mk(1, 0, "5", 1, 1, 0, 4));
        tab.push_back(mk(1, 1, "6", 0, 0, 0, 0));
        tab.push_back(mk(1, 0, "7", 0, 0, 0, 0));
        foreach (tab[i]) begin
            te = '{tab[i].o, tab[i].d, tab[i].dn, tab[i].cnt};
            cyc(tab[i].v, tab[i].c, tab[i].ch, 1'b1, te);
        end

        // longest accepted run on the default instance, then one digit too many
        mc(1, 0, "K");
        for (int i = 0; i < 15; i++) mc(1, 0, "3");
        chk("a_dig15", int'(ifa.dig_len), 15);
        chk("a_out15", int'(ifa.out), 1);
        mc(1, 0, "4");
        chk("a_too_long_out", int'(ifa.out), 0);
        chk("a_too_long_done", int'(ifa.id_done), 0);

        // underscore counts as a letter only on the ALLOW_US instance
        mc(1, 0, " ");
        mc(1, 0, "_");
        mc(1, 0, "9");
        chk("b_us_out", int'(ifb.out), 1);
        chk("a_us_out", int'(ifa.out), 0);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            ch = r < 5 ? 8'($urandom_range(8'h30, 8'h39)) :
                 r < 7 ? 8'($urandom_range(8'h61, 8'h7a)) :
                 r == 7 ? 8'h5f : r == 8 ? 8'h20 : 8'($urandom_range(0, 255));
            mc($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0, ch);
        end

        // run limit of 3 on the second instance
        mc(1, 1, " ");
        mc(1, 0, "x");
        mc(1, 0, "1");
        mc(1, 0, "2");
        mc(1, 0, "3");
        chk("b_dig3", int'(ifb.dig_len), 3);
        mc(1, 0, "4");
        chk("b_reject_out", int'(ifb.out), 0);
        chk("b_reject_dig", int'(ifb.dig_len), 0);
        chk("b_reject_cnt", int'(ifb.id_count), 0);

        // counter saturation at 3 on the second instance, then clear
        for (int t = 0; t < 5; t++) begin
            mc(1, 0, "a");
            mc(1, 0, "1");
            mc(1, 0, " ");
        end
        chk("b_sat", int'(ifb.id_count), 3);
        mc(0, 1, "a");
        chk("b_clr_cnt", int'(ifb.id_count), 0);
        chk("b_clr_out", int'(ifb.out), 0);

        // asynchronous reset in the middle of a token
        mc(1, 0, "q");
        mc(1, 0, "7");
        chk("a_q7_out", int'(ifa.out), 1);
        #3 rst_n = 1'b0;
        mreset();
        #1 chk_zero("async");
        @(posedge clk);
        #1 chk_zero("held");
        #2 rst_n = 1'b1;
        mc(1, 0, "a");
        mc(1, 0, "1");
        mc(1, 0, " ");
        chk("a_recover_cnt", int'(ifa.id_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
